// File: rtl/dispense_scheduler_pkg.sv
// Shared types and constants for the dispense scheduler: fluid codes,
// FSM states, completion status codes and the tank level width.
package dispense_pkg;

  localparam int STOCK_W = 16;

  typedef enum logic [1:0] {
    WATER   = 2'd0,
    JUICE   = 2'd1,
    CHEM    = 2'd2,
    INVALID = 2'd3
  } fluid_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    RESTOCK  = 3'd2,
    DISPENSE = 3'd3,
    DONE     = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    ST_OK           = 2'd0,
    ST_RESTOCKED_OK = 2'd1,
    ST_REJECT_STOCK = 2'd2,
    ST_REJECT_FLUID = 2'd3
  } status_e;

endpackage

// File: rtl/dispense_scheduler_if.sv
// Bundle of nozzle requests, dispenser/visit-tracker outputs, tank levels and
// the refill handshake. master = nozzle/refill side, slave = scheduler.
interface dispense_scheduler_if #(
  parameter int N_REQ = 4
);
  import dispense_pkg::*;
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] req_user;
  logic [2*N_REQ-1:0] req_fluid;
  logic [8*N_REQ-1:0] req_vol;
  logic [N_REQ-1:0]   grant;
  logic               disp_valid;
  logic [3:0]         disp_user;
  logic [1:0]         disp_fluid;
  logic [7:0]         disp_vol;
  logic               visit_inc;
  logic               done;
  logic [IW-1:0]      done_id;
  logic [1:0]         done_status;
  logic [STOCK_W-1:0] stock_water;
  logic [STOCK_W-1:0] stock_juice;
  logic [STOCK_W-1:0] stock_chem;
  logic               restock_req;
  logic [1:0]         restock_fluid;
  logic               restock_ack;

  modport master (
    output req, req_user, req_fluid, req_vol, restock_ack,
    input  grant, disp_valid, disp_user, disp_fluid, disp_vol, visit_inc,
           done, done_id, done_status, stock_water, stock_juice, stock_chem,
           restock_req, restock_fluid
  );

  modport slave (
    input  req, req_user, req_fluid, req_vol, restock_ack,
    output grant, disp_valid, disp_user, disp_fluid, disp_vol, visit_inc,
           done, done_id, done_status, stock_water, stock_juice, stock_chem,
           restock_req, restock_fluid
  );
endinterface

// File: rtl/dispense_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping. The pointer itself is owned by the scheduler.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Dispense sequencer: round-robin grant, stock check, metered dispense and
// completion reporting. Optional refill handshake under AUTO_RESTOCK_EN.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FLOW_PER_CYC = 1,
  parameter int STOCK_INIT   = 100,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  dispense_scheduler_if.slave bus
);

  sched_state_e       state_q;
  logic [IW-1:0]      rr_ptr_q, idx_q, done_id_q;
  logic [N_REQ-1:0]   grant_q;
  logic [3:0]         user_q;
  fluid_e             fluid_q;
  logic [7:0]         vol_q, remaining_q;
  logic               restocked_q, disp_valid_q, visit_inc_q, done_q;
  status_e            done_status_q;
  logic [STOCK_W-1:0] water_q, juice_q, chem_q;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic [STOCK_W-1:0] level;
  logic [7:0]         step;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  function automatic logic [7:0] flow_step(input logic [7:0] rem);
    return (rem < 8'(FLOW_PER_CYC)) ? rem : 8'(FLOW_PER_CYC);
  endfunction

  always_comb begin
    level = chem_q;
    case (fluid_q)
      WATER:   level = water_q;
      JUICE:   level = juice_q;
      default: level = chem_q;
    endcase
  end

  assign step = flow_step(remaining_q);

  // Status reported for a request that passed the stock check.
  status_e accept_status;
  assign accept_status = restocked_q ? ST_RESTOCKED_OK : ST_OK;

`ifdef AUTO_RESTOCK_EN
  logic restock_req_q;
  assign bus.restock_req   = restock_req_q;
  assign bus.restock_fluid = restock_req_q ? fluid_q : 2'd0;
`else
  logic unused_restock_ack;
  assign unused_restock_ack = bus.restock_ack;
  assign bus.restock_req    = 1'b0;
  assign bus.restock_fluid  = 2'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      idx_q         <= '0;
      done_id_q     <= '0;
      grant_q       <= '0;
      user_q        <= '0;
      fluid_q       <= WATER;
      vol_q         <= '0;
      remaining_q   <= '0;
      restocked_q   <= 1'b0;
      disp_valid_q  <= 1'b0;
      visit_inc_q   <= 1'b0;
      done_q        <= 1'b0;
      done_status_q <= ST_OK;
      water_q       <= STOCK_W'(STOCK_INIT);
      juice_q       <= STOCK_W'(STOCK_INIT);
      chem_q        <= STOCK_W'(STOCK_INIT);
`ifdef AUTO_RESTOCK_EN
      restock_req_q <= 1'b0;
`endif
    end else begin
      visit_inc_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            grant_q <= arb_gnt;
            idx_q   <= arb_idx;
            user_q  <= bus.req_user[int'(arb_idx)*4 +: 4];
            fluid_q <= fluid_e'(bus.req_fluid[int'(arb_idx)*2 +: 2]);
            vol_q   <= bus.req_vol[int'(arb_idx)*8 +: 8];
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (fluid_q == INVALID) begin
            done_q        <= 1'b1;
            done_id_q     <= idx_q;
            done_status_q <= ST_REJECT_FLUID;
            state_q       <= DONE;
          end else if ({8'd0, vol_q} > level) begin
`ifdef AUTO_RESTOCK_EN
            // Only one refill per request; a second shortfall means the
            // request can never fit in a full tank.
            if (!restocked_q) begin
              restock_req_q <= 1'b1;
              state_q       <= RESTOCK;
            end else begin
              done_q        <= 1'b1;
              done_id_q     <= idx_q;
              done_status_q <= ST_REJECT_STOCK;
              state_q       <= DONE;
            end
`else
            done_q        <= 1'b1;
            done_id_q     <= idx_q;
            done_status_q <= ST_REJECT_STOCK;
            state_q       <= DONE;
`endif
          end else begin
            visit_inc_q <= 1'b1;
            remaining_q <= vol_q;
            if (vol_q == 8'd0) begin
              done_q        <= 1'b1;
              done_id_q     <= idx_q;
              done_status_q <= accept_status;
              state_q       <= DONE;
            end else begin
              disp_valid_q <= 1'b1;
              state_q      <= DISPENSE;
            end
          end
        end
`ifdef AUTO_RESTOCK_EN
        RESTOCK: begin
          if (bus.restock_ack) begin
            case (fluid_q)
              WATER:   water_q <= STOCK_W'(STOCK_INIT);
              JUICE:   juice_q <= STOCK_W'(STOCK_INIT);
              default: chem_q  <= STOCK_W'(STOCK_INIT);
            endcase
            restocked_q   <= 1'b1;
            restock_req_q <= 1'b0;
            state_q       <= CHECK;
          end
        end
`endif
        DISPENSE: begin
          remaining_q <= remaining_q - step;
          case (fluid_q)
            WATER:   water_q <= water_q - STOCK_W'(step);
            JUICE:   juice_q <= juice_q - STOCK_W'(step);
            default: chem_q  <= chem_q - STOCK_W'(step);
          endcase
          if (remaining_q == step) begin
            disp_valid_q  <= 1'b0;
            done_q        <= 1'b1;
            done_id_q     <= idx_q;
            done_status_q <= accept_status;
            state_q       <= DONE;
          end
        end
        DONE: begin
          grant_q     <= '0;
          restocked_q <= 1'b0;
          rr_ptr_q    <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.disp_valid  = disp_valid_q;
  assign bus.disp_user   = user_q;
  assign bus.disp_fluid  = fluid_q;
  assign bus.disp_vol    = vol_q;
  assign bus.visit_inc   = visit_inc_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.done_status = done_status_q;
  assign bus.stock_water = water_q;
  assign bus.stock_juice = juice_q;
  assign bus.stock_chem  = chem_q;

endmodule

// File: doc/dispense_scheduler.md
# dispense_scheduler

Sequencing controller for the shared fluid dispenser. It arbitrates round-robin among `N_REQ` nozzle requesters and checks the per-fluid tank stock. It then meters the granted volume out over multiple cycles and pulses the visit tracker once per accepted purchase. It sits between the nozzle front-ends and the `fluid_dispenser`/`visit_tracker` pair, owns the three tank levels, and runs the restock handshake with the refill station.

## Interface
- `N_REQ`, 4: number of requesters.
- `FLOW_PER_CYC`, 1: litres dispensed per cycle, 1..255.
- `STOCK_INIT`, 100: tank level, in litres, after reset and after each restock.

- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low. While low, all state and outputs go to their reset values.
- `req` in `N_REQ`: per-requester request level. The requester holds it until it sees `done` with its `done_id`.
- `req_user` in `4*N_REQ`: user id, slice i belongs to requester i.
- `req_fluid` in `2*N_REQ`: fluid code. 0 = water, 1 = juice, 2 = chemical, 3 = invalid.
- `req_vol` in `8*N_REQ`: litres requested.
- `grant` out `N_REQ`: one-hot. Held from the first CHECK cycle through DONE.
- `disp_valid` out 1: high in DISPENSE. Qualifies `disp_user`, `disp_fluid` and `disp_vol` to the dispenser.
- `disp_user` out 4, `disp_fluid` out 2, `disp_vol` out 8: fields latched from the granted request.
- `visit_inc` out 1: one-cycle pulse to the visit tracker on acceptance.
- `done` out 1, `done_id` out `$clog2(N_REQ)`, `done_status` out 2: completion pulse with its result. Status 0 = OK, 1 = RESTOCKED_OK, 2 = REJECT_STOCK, 3 = REJECT_FLUID.
- `stock_water`, `stock_juice`, `stock_chem` out 16 each: current tank levels.
- `restock_req` out 1, `restock_fluid` out 2, `restock_ack` in 1: refill handshake.

## Operation
- **IDLE.** If `req` is non-zero, the arbiter picks the first set bit at or after `rr_ptr`, wrapping. The block latches that requester's user, fluid and volume, sets `grant`, and moves to CHECK.
- **CHECK** (one cycle):
  - fluid == 3: go to DONE with REJECT_FLUID.
  - vol > tank level: go to RESTOCK if `AUTO_RESTOCK_EN` is defined, else to DONE with REJECT_STOCK.
  - Otherwise: pulse `visit_inc`, load `remaining = vol`, and go to DISPENSE. If vol == 0, go straight to DONE with OK (or RESTOCKED_OK); `visit_inc` still pulses.
- **DISPENSE.** Each cycle, `step = min(FLOW_PER_CYC, remaining)` is subtracted from both `remaining` and the tank. When `remaining` reaches 0, go to DONE. Deasserting `req` in this state is ignored.
- **RESTOCK.** `restock_req` is high and `restock_fluid` holds the latched fluid. On the cycle `restock_ack` is sampled high, the tank is set to `STOCK_INIT`, a `restocked` flag is set, and the FSM returns to CHECK.
  - A second stock shortfall in CHECK while `restocked` is set goes to DONE with REJECT_STOCK. This happens when vol > `STOCK_INIT`, and it prevents a restock loop.
- **DONE** (one cycle). `done` pulses. Status is RESTOCKED_OK if `restocked` is set and the request was accepted. `rr_ptr` becomes granted index + 1, wrapping. `grant`, `restocked` and `disp_valid` clear. The FSM returns to IDLE.
- **Arithmetic.** Tank levels are 16-bit unsigned and never underflow, because CHECK guarantees vol ≤ level. `remaining` is 8 bits.
- **Reset values.** All outputs are 0 except the three stock outputs, which are `STOCK_INIT`. `rr_ptr` is 0 and the FSM is in IDLE.
- **Reset mid-operation.** The current transaction is abandoned, with no `done`. Tanks return to `STOCK_INIT`.

## Timing
- A `req` sampled in IDLE at edge 0 gives `grant` and CHECK at cycle 1 and DISPENSE from cycle 2.
- `disp_valid` stays high for ceil(vol/`FLOW_PER_CYC`) cycles.
- `done` follows one cycle after the last DISPENSE cycle.
- Back-to-back requests have one IDLE cycle between a DONE and the next CHECK.
- A request raised during DONE is seen in the following IDLE cycle.
- `restock_ack` must arrive while `restock_req` is high. It is ignored in any other state, and the wait for it is unbounded.

## Configuration
- `AUTO_RESTOCK_EN` defined: the RESTOCK state and handshake exist, and RESTOCKED_OK is reachable.
- Not defined: there is no RESTOCK state, `restock_req` is tied to 0, `restock_ack` is unused, and every shortfall ends in REJECT_STOCK.

## Structure
- Package `dispense_pkg` holds:
  - the `fluid_e` enum: WATER, JUICE, CHEM, INVALID;
  - the `sched_state_e` enum: IDLE, CHECK, RESTOCK, DISPENSE, DONE;
  - the `status_e` codes;
  - the `STOCK_W` = 16 constant.
- Sub-module `rr_arbiter`, parameterised on `N_REQ`. Inputs: `req` and `rr_ptr`. Outputs: one-hot `gnt` and the index. Purely combinational; the pointer register stays in the scheduler.

## Test plan
- **Basic.** Requester 0: user 1, water, 3 L, `FLOW_PER_CYC` = 1. Expect `disp_valid` for exactly 3 cycles, one `visit_inc`, `done_status` = 0, `stock_water` = 97.
- **Fairness.** `req` = 4'b1011 held continuously, each with 1 L. Expect grant order 0, 1, 3, 0 and no starvation.
- **Invalid fluid.** Fluid 3 with 5 L. Expect REJECT_FLUID at cycle 2 after the request, no `visit_inc`, tanks unchanged.
- **Stock exhaustion, macro off.** Chemical 3, then 50, then 50. The third request gets REJECT_STOCK and `stock_chem` stays 47.
- **Stock exhaustion, macro on.** Same sequence. The third request raises `restock_req` with `restock_fluid` = 2. Ack after 4 cycles gives RESTOCKED_OK and `stock_chem` = 50. A 150 L chemical request restocks, then gets REJECT_STOCK.
- **Reset mid-dispense.** Drive `reset` low during a 10 L DISPENSE. Expect no `done`, `grant` = 0, `stock_water` = 100; the next request is granted normally from IDLE.
